cg_enable_ctrl: RTL

- Clock-gate enable controller; sits directly upstream of the integrated clock-gating cell and drives its E pin.
- Opens the gated clock on an activity request and reports readiness after a programmable wake delay.
- Closes the clock after a programmable idle hold-off.
- Keeps a saturating count of gate-off events for power-management software.

---
 rtl/cg_enable_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/cg_enable_ctrl.sv
// Clock-gate enable controller: drives the ICG E pin, reports wake readiness on ACK,
// closes the clock after an idle hold-off and keeps a saturating count of gate-off events.
module cg_enable_ctrl #(
    parameter int CNT_W    = 4,
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2,
    parameter int STAT_W   = 16
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              REQ,
    input  logic              BUSY,
    input  logic              FORCE_ON,
    input  logic              CLR_STAT,
    output logic              E,
    output logic              ACK,
    output logic              GATED,
    output logic [STAT_W-1:0] GATE_CNT,
    output logic [1:0]        state_dbg
);

    // REQ/ACK handshake: the client holds REQ (or FORCE_ON) high to ask for the clock;
    // ACK high means the gated clock is running and stays running until the FSM has
    // seen IDLE_CYC+1 consecutive idle edges. ACK never rises without a prior request.
    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_WAKE  = 2'd1,
        S_ON    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             gate_evt;
    logic             act, idle;

    assign act       = REQ | FORCE_ON;
    assign idle      = !act && !BUSY;
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gate_evt = 1'b0;
        case (state)
            S_OFF: begin
                if (act) begin
                    state_nx = S_WAKE;
                    cnt_nx   = WAKE_LD;
                end
            end
            S_WAKE: begin
                // Wake always completes, even if the request is withdrawn.
                if (cnt == '0) state_nx = S_ON;
                else           cnt_nx   = cnt - 1'b1;
            end
            S_ON: begin
                if (idle) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = IDLE_LD;
                end
            end
            S_DRAIN: begin
                // Any activity cancels the hold-off, including on the expiry edge.
                if (!idle) begin
                    state_nx = S_ON;
                end else if (cnt == '0) begin
                    state_nx = S_OFF;
                    gate_evt = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = S_OFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= S_OFF;
            cnt   <= '0;
            E     <= 1'b0;
            ACK   <= 1'b0;
            GATED <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            E     <= (state_nx != S_OFF);
            ACK   <= (state_nx == S_ON) || (state_nx == S_DRAIN);
            GATED <= (state_nx == S_OFF);
        end
    end

    // Clear takes priority over a coincident gate-off increment.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            GATE_CNT <= '0;
        end else if (CLR_STAT) begin
            GATE_CNT <= '0;
        end else if (gate_evt && !(&GATE_CNT)) begin
            GATE_CNT <= GATE_CNT + 1'b1;
        end
    end

endmodule
